// File: rtl/split_pkg.sv
// ---------------------------------------------------------------------------
// split_pkg
// Shared types and constants for the shape split sequencer and its splitter.
//   - ShapeType     : opcode shape codes (LINE, TRIANGLE, CIRCLE)
//   - select codes  : splitter phase selects LL1, TL1..TL3, CA1
//   - seq_state_t   : sequencer FSM states
//   - field offsets : bit positions of color/loc1/loc2/loc3/fill in op_data
//   - first_phase() : first splitter phase of a legal shape
// ---------------------------------------------------------------------------
package split_pkg;

    typedef enum logic [3:0] {
        LINE     = 4'd0,
        TRIANGLE = 4'd1,
        CIRCLE   = 4'd2
    } ShapeType;

    localparam logic [2:0] LL1 = 3'd0;
    localparam logic [2:0] TL1 = 3'd1;
    localparam logic [2:0] TL2 = 3'd2;
    localparam logic [2:0] TL3 = 3'd3;
    localparam logic [2:0] CA1 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

    // op_data = {color[15:0], loc1[18:0], loc2[18:0], loc3[18:0], fill}
    localparam int OPDATA_W  = 74;
    localparam int COLOR_W   = 16;
    localparam int LOC_W     = 19;
    localparam int COLOR_LSB = 58;
    localparam int LOC1_LSB  = 39;
    localparam int LOC2_LSB  = 20;
    localparam int LOC3_LSB  = 1;
    localparam int FILL_BIT  = 0;

    // First splitter phase for a legal shape code.
    function automatic logic [2:0] first_phase(input logic [3:0] shape);
        logic [2:0] sel;
        case (shape)
            LINE:     sel = LL1;
            TRIANGLE: sel = TL1;
            CIRCLE:   sel = CA1;
            default:  sel = LL1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/split_sequencer_splitter.sv
// ---------------------------------------------------------------------------
// splitter
// Combinational shape splitter: picks the pair of locations for one segment.
// Ports:
//   opdata     in  74  {color, loc1, loc2, loc3, fill}
//   output_sel in  3   phase select (LL1, TL1, TL2, TL3, CA1)
//   locations  out 38  {first point, second point} of the segment
//   color      out 16  shape color
// A circle segment carries {centre = loc1, rim/radius point = loc2}.
// The fill bit is carried through opdata but not interpreted here.
// ---------------------------------------------------------------------------
module splitter
    import split_pkg::*;
(
    input  logic [73:0] opdata,
    input  logic [2:0]  output_sel,
    output logic [37:0] locations,
    output logic [15:0] color
);

    logic [18:0] loc1_s;
    logic [18:0] loc2_s;
    logic [18:0] loc3_s;
    logic        unused_fill_s;

    assign loc1_s        = opdata[LOC1_LSB +: LOC_W];
    assign loc2_s        = opdata[LOC2_LSB +: LOC_W];
    assign loc3_s        = opdata[LOC3_LSB +: LOC_W];
    assign color         = opdata[COLOR_LSB +: COLOR_W];
    assign unused_fill_s = opdata[FILL_BIT];

    // Select the endpoint pair for the current phase.
    always_comb begin
        locations = 38'd0;
        case (output_sel)
            LL1:     locations = {loc1_s, loc2_s};
            TL1:     locations = {loc1_s, loc2_s};
            TL2:     locations = {loc1_s, loc3_s};
            TL3:     locations = {loc2_s, loc3_s};
            CA1:     locations = {loc1_s, loc2_s};
            default: locations = 38'd0;
        endcase
    end

endmodule

// File: rtl/split_sequencer.sv
// ---------------------------------------------------------------------------
// split_sequencer
// Accepts one shape opcode at a time and steps the splitter through the
// shape's segment phases, launching each segment on the rasterizer with a
// draw_start / draw_done handshake.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   op_valid/op_ready opcode handshake (ready only while idle)
//   op_shape, op_data opcode shape code and payload
//   abort             synchronous cancel of the shape in progress
//   draw_start        one-cycle segment launch pulse
//   draw_circle       current segment is a circle
//   draw_done         rasterizer finished the current segment
//   locations, color  splitter outputs for the current phase
//   busy              shape in progress
//   shape_done        pulse after the last segment completes
//   op_err            pulse after an illegal shape code is dropped
//   err_count         saturating reject counter (only with SPLIT_SEQ_ERRCNT_EN)
// Optional feature macro: SPLIT_SEQ_ERRCNT_EN
// ---------------------------------------------------------------------------
module split_sequencer
    import split_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_shape,
    input  logic [73:0] op_data,
    input  logic        abort,
    output logic        draw_start,
    output logic        draw_circle,
    input  logic        draw_done,
    output logic [37:0] locations,
    output logic [15:0] color,
    output logic        busy,
    output logic        shape_done,
    output logic        op_err
`ifdef SPLIT_SEQ_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    seq_state_t  state_r;
    logic [73:0] opdata_r;
    logic [2:0]  phase_r;
    logic        shape_legal_s;
    logic        last_phase_s;
    logic        reject_s;

    assign shape_legal_s = (op_shape <= 4'd2);
    // Only the first two triangle phases have a successor.
    assign last_phase_s  = (phase_r != TL1) && (phase_r != TL2);
    assign reject_s      = (state_r == ST_IDLE) && op_valid && !shape_legal_s;

    // Sequencer FSM with all control outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            opdata_r    <= 74'd0;
            phase_r     <= LL1;
            op_ready    <= 1'b1;
            draw_start  <= 1'b0;
            draw_circle <= 1'b0;
            busy        <= 1'b0;
            shape_done  <= 1'b0;
            op_err      <= 1'b0;
        end else begin
            draw_start <= 1'b0;
            shape_done <= 1'b0;
            op_err     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // abort is deliberately ignored while idle
                    if (op_valid) begin
                        if (shape_legal_s) begin
                            opdata_r    <= op_data;
                            phase_r     <= first_phase(op_shape);
                            draw_circle <= (op_shape == CIRCLE);
                            state_r     <= ST_ISSUE;
                            draw_start  <= 1'b1;
                            busy        <= 1'b1;
                            op_ready    <= 1'b0;
                        end else begin
                            op_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                        op_ready <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                        op_ready <= 1'b1;
                    end else if (draw_done) begin
                        if (last_phase_s) begin
                            state_r    <= ST_IDLE;
                            shape_done <= 1'b1;
                            busy       <= 1'b0;
                            op_ready   <= 1'b1;
                        end else begin
                            phase_r    <= phase_r + 3'd1;
                            state_r    <= ST_ISSUE;
                            draw_start <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SPLIT_SEQ_ERRCNT_EN
    // Saturating count of rejected opcodes, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (reject_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    logic unused_reject_s;
    assign unused_reject_s = reject_s;
`endif

    splitter u_splitter (
        .opdata     (opdata_r),
        .output_sel (phase_r),
        .locations  (locations),
        .color      (color)
    );

endmodule

// File: tb/tb_split_sequencer.sv
// Self-checking bench for split_sequencer with a shape-level reference model.
module tb_split_sequencer;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_shape;
    logic [73:0] op_data;
    logic        abort;
    logic        draw_start;
    logic        draw_circle;
    logic        draw_done;
    logic [37:0] locations;
    logic [15:0] color;
    logic        busy;
    logic        shape_done;
    logic        op_err;
`ifdef SPLIT_SEQ_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int checks   = 0;
    int failures = 0;
    int model_errs = 0;

    // Model of what the splitter currently holds: last accepted shape/data/segment.
    int          last_shape = 0;
    logic [73:0] last_data  = 74'd0;
    int          last_k     = 0;

    split_sequencer dut (
        .clk         (tb_clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_shape    (op_shape),
        .op_data     (op_data),
        .abort       (abort),
        .draw_start  (draw_start),
        .draw_circle (draw_circle),
        .draw_done   (draw_done),
        .locations   (locations),
        .color       (color),
        .busy        (busy),
        .shape_done  (shape_done),
        .op_err      (op_err)
`ifdef SPLIT_SEQ_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [73:0] make_op(input logic [15:0] c, input logic [18:0] l1,
                                            input logic [18:0] l2, input logic [18:0] l3,
                                            input logic f);
        return {c, l1, l2, l3, f};
    endfunction

    function automatic int n_segs(input int shape);
        return (shape == 1) ? 3 : 1;
    endfunction

    // Segment k of a shape: triangle edges are (1,2), (1,3), (2,3); line/circle use (1,2).
    function automatic logic [37:0] seg_loc(input int shape, input logic [73:0] d, input int k);
        logic [18:0] l [3];
        int a;
        int b;
        l[0] = d[57:39];
        l[1] = d[38:20];
        l[2] = d[19:1];
        a = 0;
        b = 1;
        if (shape == 1 && k == 1) b = 2;
        if (shape == 1 && k == 2) begin a = 1; b = 2; end
        return {l[a], l[b]};
    endfunction

    function automatic logic [73:0] rand_op();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[73:0];
    endfunction

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Present one legal opcode and drive it to completion; ends in the shape_done cycle.
    task automatic run_shape(input int shape, input logic [73:0] d, input int dly, input bit stray_issue);
        logic [37:0] exp_loc;
        op_valid = 1'b1;
        op_shape = shape[3:0];
        op_data  = d;
        step();
        op_valid = 1'b0;
        op_data  = rand_op();
        last_shape = shape;
        last_data  = d;
        for (int k = 0; k < n_segs(shape); k++) begin
            exp_loc = seg_loc(shape, d, k);
            last_k  = k;
            checks++;
            if ({draw_start, busy, op_ready, shape_done} !== 4'b1100) begin
                failures++;
                $display("FAIL issue_flags shape=%0d seg=%0d got=%b exp=1100", shape, k,
                         {draw_start, busy, op_ready, shape_done});
            end
            checks++;
            if (locations !== exp_loc) begin
                failures++;
                $display("FAIL issue_loc shape=%0d seg=%0d got=%h exp=%h", shape, k, locations, exp_loc);
            end
            checks++;
            if ({draw_circle, color} !== {(shape == 2), d[73:58]}) begin
                failures++;
                $display("FAIL issue_circle_color shape=%0d got=%b/%h exp=%b/%h", shape,
                         draw_circle, color, (shape == 2), d[73:58]);
            end
            if (stray_issue && k == 0) draw_done = 1'b1;
            step();
            draw_done = 1'b0;
            for (int w = 0; w <= dly; w++) begin
                checks++;
                if ({draw_start, busy, shape_done, locations, color} !== {3'b010, exp_loc, d[73:58]}) begin
                    failures++;
                    $display("FAIL wait_hold shape=%0d seg=%0d got=%b%b%b %h %h exp=010 %h %h", shape, k,
                             draw_start, busy, shape_done, locations, color, exp_loc, d[73:58]);
                end
                if (w < dly) step();
            end
            draw_done = 1'b1;
            step();
            draw_done = 1'b0;
        end
        checks++;
        if ({shape_done, op_ready, busy, draw_start} !== 4'b1100) begin
            failures++;
            $display("FAIL shape_done shape=%0d got=%b exp=1100", shape,
                     {shape_done, op_ready, busy, draw_start});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op_shape = 4'd0; op_data = 74'd0; abort = 1'b0; draw_done = 1'b0;
        step();
        step();
        checks++;
        if ({op_ready, draw_start, draw_circle, busy, shape_done, op_err, locations, color} !==
            {6'b100000, 38'd0, 16'd0}) begin
            failures++;
            $display("FAIL reset_values got=%b%b%b%b%b%b %h %h exp=100000 0 0", op_ready, draw_start,
                     draw_circle, busy, shape_done, op_err, locations, color);
        end
`ifdef SPLIT_SEQ_ERRCNT_EN
        checks++;
        if (err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_err_count got=%0d exp=0", err_count);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_line();
        run_shape(0, make_op(16'hBEEF, 19'h12345, 19'h00ABC, 19'h00000, 1'b1), 4, 1'b0);
        step();
        checks++;
        if ({shape_done, op_ready} !== 2'b01) begin
            failures++;
            $display("FAIL line_after got=%b exp=01", {shape_done, op_ready});
        end
    endtask

    task automatic test_triangle();
        run_shape(1, make_op(16'h1234, 19'd1, 19'd2, 19'd3, 1'b0), 1, 1'b0);
        step();
    endtask

    task automatic test_circle();
        run_shape(2, make_op(16'hC1C1, 19'h7FFFF, 19'h00100, 19'h55555, 1'b1), 3, 1'b0);
        step();
    endtask

    task automatic test_illegal(input logic [3:0] code);
        logic [37:0] exp_loc;
        exp_loc = seg_loc(last_shape, last_data, last_k);
        op_valid = 1'b1;
        op_shape = code;
        op_data  = rand_op();
        step();
        op_valid = 1'b0;
        model_errs++;
        checks++;
        if ({op_err, busy, op_ready, draw_start, locations} !== {4'b1010, exp_loc}) begin
            failures++;
            $display("FAIL illegal_pulse code=%0d got=%b%b%b%b %h exp=1010 %h", code, op_err, busy,
                     op_ready, draw_start, locations, exp_loc);
        end
        step();
        checks++;
        if ({op_err, busy} !== 2'b00) begin
            failures++;
            $display("FAIL illegal_after code=%0d got=%b exp=00", code, {op_err, busy});
        end
    endtask

`ifdef SPLIT_SEQ_ERRCNT_EN
    task automatic test_err_saturate();
        int exp_cnt;
        op_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op_shape = 4'($urandom_range(3, 15));
            step();
            model_errs++;
        end
        op_valid = 1'b0;
        step();
        exp_cnt = (model_errs > 255) ? 255 : model_errs;
        checks++;
        if (err_count !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL err_count_sat got=%0d exp=%0d", err_count, exp_cnt);
        end
    endtask
`endif

    task automatic test_abort();
        logic [73:0] d;
        d = rand_op();
        // abort in the second triangle WAIT
        op_valid = 1'b1; op_shape = 4'd1; op_data = d;
        step();
        op_valid = 1'b0;
        step();
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        checks++;
        if ({draw_start, locations} !== {1'b1, seg_loc(1, d, 1)}) begin
            failures++;
            $display("FAIL abort_seg2 got=%b %h exp=1 %h", draw_start, locations, seg_loc(1, d, 1));
        end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        last_shape = 1; last_data = d; last_k = 1;
        checks++;
        if ({busy, op_ready, shape_done, draw_start} !== 4'b0100) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=0100", {busy, op_ready, shape_done, draw_start});
        end
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        checks++;
        if ({busy, op_ready, shape_done, draw_start, locations} !== {4'b0100, seg_loc(1, d, 1)}) begin
            failures++;
            $display("FAIL abort_late_done got=%b %h exp=0100 %h", {busy, op_ready, shape_done, draw_start},
                     locations, seg_loc(1, d, 1));
        end
        // abort together with draw_done in the first WAIT: no relaunch
        d = rand_op();
        op_valid = 1'b1; op_shape = 4'd1; op_data = d;
        step();
        op_valid = 1'b0;
        step();
        abort = 1'b1; draw_done = 1'b1;
        step();
        abort = 1'b0; draw_done = 1'b0;
        last_shape = 1; last_data = d; last_k = 0;
        checks++;
        if ({busy, op_ready, shape_done, draw_start} !== 4'b0100) begin
            failures++;
            $display("FAIL abort_with_done got=%b exp=0100", {busy, op_ready, shape_done, draw_start});
        end
        // abort while idle does not block an opcode
        d = rand_op();
        abort = 1'b1; op_valid = 1'b1; op_shape = 4'd0; op_data = d;
        step();
        abort = 1'b0; op_valid = 1'b0;
        last_shape = 0; last_data = d; last_k = 0;
        checks++;
        if ({draw_start, busy, locations} !== {2'b11, seg_loc(0, d, 0)}) begin
            failures++;
            $display("FAIL abort_in_idle got=%b%b %h exp=11 %h", draw_start, busy, locations, seg_loc(0, d, 0));
        end
        step();
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        checks++;
        if (shape_done !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_idle_done got=%b exp=1", shape_done);
        end
        step();
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op_shape = 4'd2; op_data = rand_op();
        step();
        op_valid = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        last_shape = 0; last_data = 74'd0; last_k = 0;
        checks++;
        if ({op_ready, draw_start, draw_circle, busy, shape_done, op_err, locations, color} !==
            {6'b100000, 38'd0, 16'd0}) begin
            failures++;
            $display("FAIL reset_mid got=%b%b%b%b%b%b %h %h exp=100000 0 0", op_ready, draw_start,
                     draw_circle, busy, shape_done, op_err, locations, color);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_stray_done();
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        checks++;
        if ({busy, shape_done, draw_start, op_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL stray_idle got=%b exp=0001", {busy, shape_done, draw_start, op_ready});
        end
        run_shape(0, rand_op(), 2, 1'b1);
        step();
    endtask

    task automatic test_back_to_back();
        run_shape(0, rand_op(), 0, 1'b0);
        run_shape(0, rand_op(), 1, 1'b0);
        run_shape(1, rand_op(), 0, 1'b0);
        step();
    endtask

    task automatic test_random();
        int sh;
        for (int i = 0; i < 25; i++) begin
            sh = $urandom_range(0, 3);
            if (sh == 3) test_illegal(4'($urandom_range(3, 15)));
            else begin
                run_shape(sh, rand_op(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_triangle();
        test_circle();
        test_illegal(4'd5);
`ifdef SPLIT_SEQ_ERRCNT_EN
        test_err_saturate();
`endif
        test_abort();
        test_reset_mid();
        test_stray_done();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/split_sequencer.md
# split_sequencer

Controller that accepts one shape opcode at a time and steps the combinational splitter through that shape's segment phases. Each segment is handed to the downstream rasterizer with a start/done handshake. The block sits between the opcode decoder/FIFO and the line/circle rasterizer, and owns the splitter's `opdata` and `output_sel` inputs.

## Interface
Parameters:
- none. All widths are fixed by the opcode format.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  decoder presents an opcode.
- `op_ready`  out  1  block can accept an opcode.
- `op_shape`  in  4  shape code: `LINE`=0, `TRIANGLE`=1, `CIRCLE`=2.
- `op_data`  in  74  `{color[15:0], loc1[18:0], loc2[18:0], loc3[18:0], fill}`.
- `abort`  in  1  synchronous cancel of the current shape.
- `draw_start`  out  1  one-cycle pulse that launches one segment.
- `draw_circle`  out  1  1 = current segment is a circle, 0 = line; valid while `busy`.
- `draw_done`  in  1  rasterizer has finished the current segment (pulse).
- `locations`  out  38  splitter output for the current phase.
- `color`  out  16  splitter color output.
- `busy`  out  1  a shape is in progress.
- `shape_done`  out  1  one-cycle pulse when the last segment of a shape completes.
- `op_err`  out  1  one-cycle pulse when an illegal `op_shape` is rejected.
- `err_count`  out  8  count of rejected opcodes; present only with `SPLIT_SEQ_ERRCNT_EN`.

## Operation
- Handshake:
  - `op_ready` = 1 only in IDLE.
  - An opcode is accepted on a rising edge where `op_valid && op_ready`.
  - On acceptance, `op_data` is latched into `opdata_q`, which drives the splitter.
- Phase lists (`output_sel`):
  - LINE: LL1 (0).
  - TRIANGLE: TL1 (1), TL2 (2), TL3 (3).
  - CIRCLE: CA1 (4).
- Illegal shape (`op_shape` > 2):
  - The opcode is accepted and dropped.
  - `op_err` pulses on the next cycle.
  - State stays IDLE; `opdata_q` is unchanged.
- States:
  - IDLE: wait for an accepted legal opcode, then go to ISSUE with phase = first phase of the shape.
  - ISSUE: `draw_start` = 1 for this cycle only; always go to WAIT.
  - WAIT: hold `output_sel`. On `draw_done`: if more phases remain, advance the phase and go to ISSUE; otherwise go to IDLE and pulse `shape_done`.
- `draw_done` is sampled only in WAIT. Any `draw_done` during IDLE or ISSUE is ignored.
- `abort` has priority over every other transition:
  - From ISSUE or WAIT, go to IDLE on the next edge.
  - No `shape_done` pulse; `draw_start` is suppressed that cycle.
  - In IDLE, `abort` has no effect; an opcode presented in the same cycle is still accepted.
- `draw_circle` = 1 iff the latched shape is `CIRCLE`.
- `busy` = 1 in ISSUE and WAIT.
- The `fill` bit passes through in `opdata_q` and is not interpreted.

## Timing
- Reset values:
  - state IDLE, so `op_ready` = 1.
  - `opdata_q` = 0, `output_sel` = 0.
  - `draw_start` = 0, `draw_circle` = 0, `busy` = 0.
  - `shape_done` = 0, `op_err` = 0, `err_count` = 0.
- Accept at edge N: ISSUE during cycle N+1, so `draw_start` is high in N+1, with `output_sel` and `locations` already valid. WAIT from N+2.
- `draw_done` sampled at edge M:
  - Next phase: ISSUE in cycle M+1.
  - Last phase: `shape_done` and `op_ready` are both high in cycle M+1.
  - The earliest next acceptance is therefore edge M+1 (back-to-back).
- `locations` and `color` follow `opdata_q` and `output_sel` combinationally, through the splitter.
- Reset mid-shape forces IDLE immediately and asynchronously; no pulses are generated.

## Configuration
- `SPLIT_SEQ_ERRCNT_EN` defined:
  - 8-bit `err_count` port exists.
  - Increments on each `op_err`; saturates at 255.
  - Cleared only by `rst`.
- `SPLIT_SEQ_ERRCNT_EN` undefined:
  - Port and counter are absent.
  - `op_err` behaves identically.

## Structure
- `split_pkg` holds:
  - `ShapeType` enum (`LINE`, `TRIANGLE`, `CIRCLE`).
  - Select constants `LL1`=0, `TL1`=1, `TL2`=2, `TL3`=3, `CA1`=4.
  - The sequencer state enum.
  - Opcode field offsets.
- Sub-module: one instance of the existing `splitter`.
  - `opdata` = `opdata_q`.
  - `output_sel` = phase register.
  - `locations` and `color` go straight to the ports.

## Test plan
- Line: shape 0, loc1=0x12345, loc2=0x00ABC.
  - One `draw_start` with `locations`={0x12345, 0x00ABC}.
  - `draw_done` after 5 cycles -> `shape_done` the next cycle; `op_ready` = 1.
- Triangle: shape 1, loc1=1, loc2=2, loc3=3.
  - Three `draw_start`s with `locations` {1,2}, then {1,3}, then {2,3}.
  - `shape_done` only after the third `draw_done`.
- Circle: shape 2.
  - `draw_circle` = 1, `output_sel` = 4, single segment.
  - `color` equals `op_data[73:58]` throughout.
- Illegal shape 5:
  - `op_err` pulses once; `busy` stays 0.
  - With the macro, 300 illegal opcodes -> `err_count` = 255.
- Abort and reset mid-shape:
  - `abort` in the second triangle WAIT -> IDLE next cycle, no `shape_done`.
  - A late `draw_done` is ignored.
  - `rst` mid-WAIT gives all outputs their reset values.
- Stray `draw_done` in IDLE and in ISSUE is ignored.
  - Back-to-back line opcodes are accepted at M+1.
